// File: rtl/tbird_pkg.sv
// tbird_pkg: shared types and constants for the tbird_seq turn-signal sequencer.
//   state_e   : sequencer state encoding. The hazard states exist only when
//               TBIRD_HAZARD_EN is defined; otherwise the encoding is 2 bits.
//   DIV_W_DEF : default width of the step-period divider.
package tbird_pkg;

  localparam int DIV_W_DEF = 16;

`ifdef TBIRD_HAZARD_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SWEEP   = 3'd1,
    BLANK   = 3'd2,
    HAZ_ON  = 3'd3,
    HAZ_OFF = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    BLANK = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/tbird_tick_gen.sv
// tbird_tick_gen: step prescaler for tbird_seq.
//   clk  in         clock
//   rst  in         asynchronous active-high reset
//   clr  in         restart the count (state/idx change or idle)
//   div  in  DIV_W  step period minus 1
//   tick out        count has reached div; the current pattern ends this cycle
// The compare is >= so that lowering div below the running count ends the
// current pattern on the next clock instead of wrapping the counter.
module tbird_tick_gen
  import tbird_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = (cnt_q >= div);

  always_comb begin
    cnt_d = clr ? '0 : cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tbird_seq.sv
// tbird_seq: parametrised Thunderbird turn-signal sequencer.
//   clk          in          clock
//   rst          in          asynchronous active-high reset
//   enable       in          turn signal requested
//   isleft       in          1 = left sweep, 0 = right; latched at sweep start
//   hazard       in          hazard request (only with TBIRD_HAZARD_EN)
//   div          in  DIV_W   step period minus 1, in clocks
//   left_lamps   out LAMPS   left lamp drive, bit 0 innermost (registered)
//   right_lamps  out LAMPS   right lamp drive, bit 0 innermost (registered)
//   busy         out         state != IDLE (registered)
//   step         out         one-cycle pulse after each tick-driven advance
// Optional feature macro: TBIRD_HAZARD_EN adds the hazard port and states.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | all lamps off, waiting for enable (or hazard)
// SWEEP   | latched side shows low idx+1 lamps lit
// BLANK   | all off between sweeps
// HAZ_ON  | both sides fully lit (hazard build only)
// HAZ_OFF | both sides off (hazard build only)
module tbird_seq
  import tbird_pkg::*;
#(
  parameter int LAMPS = 3,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             isleft,
`ifdef TBIRD_HAZARD_EN
  input  logic             hazard,
`endif
  input  logic [DIV_W-1:0] div,
  output logic [LAMPS-1:0] left_lamps,
  output logic [LAMPS-1:0] right_lamps,
  output logic             busy,
  output logic             step
);

  localparam int IDX_W = (LAMPS > 1) ? $clog2(LAMPS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAMPS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             side_q, side_d;
  logic [LAMPS-1:0] left_q, left_d;
  logic [LAMPS-1:0] right_q, right_d;
  logic             busy_q, busy_d;
  logic             step_q, step_d;
  logic [LAMPS-1:0] pat;
  logic             tick;
  logic             clr;

  // Any change of state or idx starts a fresh pattern period.
  assign clr = (state_d != state_q) || (idx_d != idx_q) || (state_q == IDLE);

  tbird_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .div  (div),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    side_d  = side_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SWEEP;
          idx_d   = '0;
          side_d  = isleft;
        end
      end
      SWEEP: begin
        if (!enable) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (tick) begin
          step_d = 1'b1;
          if (idx_q < IDX_LAST) idx_d = idx_q + IDX_W'(1);
          else                  state_d = BLANK;
        end
      end
      BLANK: begin
        if (tick) begin
          idx_d = '0;
          if (enable) begin
            state_d = SWEEP;
            side_d  = isleft;
            step_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
`ifdef TBIRD_HAZARD_EN
      HAZ_ON: begin
        if (!hazard) state_d = IDLE;
        else if (tick) begin
          state_d = HAZ_OFF;
          step_d  = 1'b1;
        end
      end
      HAZ_OFF: begin
        if (!hazard) state_d = IDLE;
        else if (tick) begin
          state_d = HAZ_ON;
          step_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
`ifdef TBIRD_HAZARD_EN
    // Hazard outranks any turn-signal activity.
    if (hazard && (state_q == IDLE || state_q == SWEEP || state_q == BLANK)) begin
      state_d = HAZ_ON;
      idx_d   = '0;
      side_d  = side_q;
      step_d  = 1'b0;
    end
`endif
  end

  // Outputs decode from next-state so they land on the same edge as the state.
  always_comb begin
    for (int i = 0; i < LAMPS; i++) pat[i] = (IDX_W'(i) <= idx_d);
    left_d  = '0;
    right_d = '0;
    case (state_d)
      SWEEP: begin
        if (side_d) left_d  = pat;
        else        right_d = pat;
      end
`ifdef TBIRD_HAZARD_EN
      HAZ_ON: begin
        left_d  = '1;
        right_d = '1;
      end
`endif
      default: begin
        left_d  = '0;
        right_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      side_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      side_q  <= side_d;
      left_q  <= left_d;
      right_q <= right_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
    end
  end

  assign left_lamps  = left_q;
  assign right_lamps = right_q;
  assign busy        = busy_q;
  assign step        = step_q;

endmodule

// File: tb/tb_tbird_seq.sv
// tb_tbird_seq: directed self-checking bench for tbird_seq (LAMPS=3, DIV_W=16).
module tb_tbird_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        isleft;
`ifdef TBIRD_HAZARD_EN
  logic        hazard;
`endif
  logic [15:0] div;
  logic [2:0]  left_lamps;
  logic [2:0]  right_lamps;
  logic        busy;
  logic        step;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] pats [4];

  tbird_seq #(.LAMPS(3), .DIV_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .isleft      (isleft),
`ifdef TBIRD_HAZARD_EN
    .hazard      (hazard),
`endif
    .div         (div),
    .left_lamps  (left_lamps),
    .right_lamps (right_lamps),
    .busy        (busy),
    .step        (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Advance one clock, then check both lamp banks, busy and step.
  task automatic stepc(input string tag, input logic [2:0] l, input logic [2:0] r,
                       input logic b, input logic s);
    tick_clk();
    chk({tag, ".left"},  {29'd0, left_lamps},  {29'd0, l});
    chk({tag, ".right"}, {29'd0, right_lamps}, {29'd0, r});
    chk({tag, ".busy"},  {31'd0, busy},        {31'd0, b});
    chk({tag, ".step"},  {31'd0, step},        {31'd0, s});
  endtask

  initial begin
    pats[0] = 3'b001; pats[1] = 3'b011; pats[2] = 3'b111; pats[3] = 3'b000;
    rst = 1'b1; enable = 1'b0; isleft = 1'b1; div = 16'd3;
`ifdef TBIRD_HAZARD_EN
    hazard = 1'b0;
`endif
    tick_clk(); tick_clk();
    chk("rst.left",  {29'd0, left_lamps},  32'd0);
    chk("rst.right", {29'd0, right_lamps}, 32'd0);
    chk("rst.busy",  {31'd0, busy},        32'd0);
    chk("rst.step",  {31'd0, step},        32'd0);
    rst = 1'b0;
    tick_clk();

    // Left sweep, div=3: each pattern 4 clocks, two full cycles.
    enable = 1'b1; isleft = 1'b1; div = 16'd3;
    for (int k = 0; k < 32; k++)
      stepc("left_d3", pats[(k / 4) % 4], 3'b000, 1'b1, (k > 0) && (k % 4 == 0));
    enable = 1'b0;
    stepc("left_d3_stop", 3'b000, 3'b000, 1'b0, 1'b0);

    // Right sweep, div=0: advance every clock.
    enable = 1'b1; isleft = 1'b0; div = 16'd0;
    for (int k = 0; k < 8; k++)
      stepc("right_d0", 3'b000, pats[k % 4], 1'b1, k > 0);
    enable = 1'b0;
    stepc("right_d0_stop", 3'b000, 3'b000, 1'b0, 1'b0);

    // isleft toggled mid-sweep only takes effect at the next sweep start.
    enable = 1'b1; isleft = 1'b1; div = 16'd1;
    stepc("tog_e1", 3'b001, 3'b000, 1'b1, 1'b0);
    stepc("tog_e2", 3'b001, 3'b000, 1'b1, 1'b0);
    stepc("tog_e3", 3'b011, 3'b000, 1'b1, 1'b1);
    isleft = 1'b0;
    stepc("tog_e4", 3'b011, 3'b000, 1'b1, 1'b0);
    stepc("tog_e5", 3'b111, 3'b000, 1'b1, 1'b1);
    stepc("tog_e6", 3'b111, 3'b000, 1'b1, 1'b0);
    stepc("tog_e7", 3'b000, 3'b000, 1'b1, 1'b1);
    stepc("tog_e8", 3'b000, 3'b000, 1'b1, 1'b0);
    stepc("tog_e9", 3'b000, 3'b001, 1'b1, 1'b1);
    stepc("tog_e10", 3'b000, 3'b001, 1'b1, 1'b0);
    stepc("tog_e11", 3'b000, 3'b011, 1'b1, 1'b1);
    enable = 1'b0;
    stepc("tog_drop", 3'b000, 3'b000, 1'b0, 1'b0);

    // Release during left 011: off on the next edge.
    enable = 1'b1; isleft = 1'b1;
    stepc("rel_e1", 3'b001, 3'b000, 1'b1, 1'b0);
    stepc("rel_e2", 3'b001, 3'b000, 1'b1, 1'b0);
    stepc("rel_e3", 3'b011, 3'b000, 1'b1, 1'b1);
    enable = 1'b0;
    stepc("rel_drop", 3'b000, 3'b000, 1'b0, 1'b0);

    // div lowered from 10 to 2 while cnt=7.
    enable = 1'b1; div = 16'd10;
    stepc("div_e1", 3'b001, 3'b000, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++)
      stepc("div_hold10", 3'b001, 3'b000, 1'b1, 1'b0);
    div = 16'd2;
    stepc("div_lower", 3'b011, 3'b000, 1'b1, 1'b1);
    stepc("div_h3a", 3'b011, 3'b000, 1'b1, 1'b0);
    stepc("div_h3b", 3'b011, 3'b000, 1'b1, 1'b0);
    stepc("div_next", 3'b111, 3'b000, 1'b1, 1'b1);
    enable = 1'b0;
    stepc("div_stop", 3'b000, 3'b000, 1'b0, 1'b0);

    // Asynchronous reset during 011.
    enable = 1'b1; div = 16'd3;
    stepc("rst_e1", 3'b001, 3'b000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      stepc("rst_hold", 3'b001, 3'b000, 1'b1, 1'b0);
    stepc("rst_e5", 3'b011, 3'b000, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst.left", {29'd0, left_lamps}, 32'd0);
    chk("arst.busy", {31'd0, busy},       32'd0);
    chk("arst.step", {31'd0, step},       32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    stepc("arst_restart", 3'b001, 3'b000, 1'b1, 1'b0);
    enable = 1'b0;
    stepc("arst_stop", 3'b000, 3'b000, 1'b0, 1'b0);

`ifdef TBIRD_HAZARD_EN
    // Hazard with enable also high, div=1: 2 on, 2 off.
    enable = 1'b1; hazard = 1'b1; div = 16'd1;
    stepc("haz_e1", 3'b111, 3'b111, 1'b1, 1'b0);
    stepc("haz_e2", 3'b111, 3'b111, 1'b1, 1'b0);
    stepc("haz_e3", 3'b000, 3'b000, 1'b1, 1'b1);
    stepc("haz_e4", 3'b000, 3'b000, 1'b1, 1'b0);
    stepc("haz_e5", 3'b111, 3'b111, 1'b1, 1'b1);
    stepc("haz_e6", 3'b111, 3'b111, 1'b1, 1'b0);
    hazard = 1'b0;
    stepc("haz_drop", 3'b000, 3'b000, 1'b0, 1'b0);
    stepc("haz_sweep", 3'b001, 3'b000, 1'b1, 1'b0);
    hazard = 1'b1;
    stepc("haz_from_sweep", 3'b111, 3'b111, 1'b1, 1'b0);
    hazard = 1'b0; enable = 1'b0;
    stepc("haz_end", 3'b000, 3'b000, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
